// File: rtl/mux2x1_rr_arbiter.sv
// Round-robin arbiter owning the select of a WIDTH-bit 2:1 mux.
// Grants are held for at most MAXBURST cycles while the other side waits, with gapless handover.
module mux2x1_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAXBURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             s,
    output logic             valid,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    localparam logic [7:0] CNT_MAX = 8'(MAXBURST - 1);

    state_t     state, next_state;
    logic [7:0] cnt, next_cnt;
    logic       last, next_last;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
        next_state = state;
        next_cnt   = cnt;
        next_last  = last;
        case (state)
            IDLE: begin
                next_cnt = '0;
                // On contention the requester that was not served last wins.
                if (req0 && (!req1 || last))
                    next_state = G0;
                else if (req1)
                    next_state = G1;
            end
            G0: begin
                if (!req0 || cnt == CNT_MAX) begin
                    next_last = 1'b0;
                    next_cnt  = '0;
                    if (req1)      next_state = G1;
                    else if (req0) next_state = G0;
                    else           next_state = IDLE;
                end else begin
                    next_cnt = cnt + 8'd1;
                end
            end
            G1: begin
                if (!req1 || cnt == CNT_MAX) begin
                    next_last = 1'b1;
                    next_cnt  = '0;
                    if (req0)      next_state = G0;
                    else if (req1) next_state = G1;
                    else           next_state = IDLE;
                end else begin
                    next_cnt = cnt + 8'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Grants and select are registered from the next state so they change right after the deciding edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            s     <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            last  <= next_last;
            gnt0  <= (next_state == G0);
            gnt1  <= (next_state == G1);
            if (next_state == G0)
                s <= 1'b0;
            else if (next_state == G1)
                s <= 1'b1;
        end
    end

    assign valid = gnt0 | gnt1;
    assign y     = valid ? (s ? a1 : a0) : '0;

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Scoreboard bench: a driver pushes hand-computed expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT (MAXBURST=4) or a MAXBURST=1 copy.
module tb_mux2x1_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1, req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = '0, a1 = '0;
    logic       gnt0, gnt1, s, valid;
    logic [7:0] y;

    logic       reset_b = 1'b1, req0_b = 1'b0, req1_b = 1'b0;
    logic [7:0] a0_b = '0, a1_b = '0;
    logic       gnt0_b, gnt1_b, s_b, valid_b;
    logic [7:0] y_b;

    int checks   = 0;
    int failures = 0;
    int item_no  = 0;

    typedef struct {
        bit         which;
        int         idx;
        logic [11:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mux2x1_rr_arbiter #(.WIDTH(8), .MAXBURST(4)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .a0(a0), .a1(a1),
        .gnt0(gnt0), .gnt1(gnt1), .s(s), .valid(valid), .y(y)
    );

    mux2x1_rr_arbiter #(.WIDTH(8), .MAXBURST(1)) dut_b (
        .clk(clk), .reset(reset_b), .req0(req0_b), .req1(req1_b), .a0(a0_b), .a1(a1_b),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .s(s_b), .valid(valid_b), .y(y_b)
    );

    // Monitor: compares {gnt0,gnt1,s,valid,y} just before the driver changes inputs.
    initial begin
        exp_t       e;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = e.which ? {gnt0_b, gnt1_b, s_b, valid_b, y_b}
                              : {gnt0, gnt1, s, valid, y};
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL dut%0d_item%0d g0_g1_s_valid_y got=%b_%b_%b_%b_%h required=%b_%b_%b_%b_%h",
                             e.which, e.idx, act[11], act[10], act[9], act[8], act[7:0],
                             e.exp[11], e.exp[10], e.exp[9], e.exp[8], e.exp[7:0]);
                end
            end
        end
    end

    // Drive one cycle of inputs and push the outputs expected after the next rising edge.
    task automatic step(input bit which, input logic rst, input logic r0, input logic r1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic eg0, input logic eg1, input logic es,
                        input logic [7:0] ey, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (which) begin
                reset_b = rst; req0_b = r0; req1_b = r1; a0_b = d0; a1_b = d1;
            end else begin
                reset = rst; req0 = r0; req1 = r1; a0 = d0; a1 = d1;
            end
            e.which = which;
            e.idx   = item_no++;
            e.exp   = {eg0, eg1, es, eg0 | eg1, ey};
            sb.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both requesting, then contention: 4x a0, 4x a1, back to a0.
        step(0, 1, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00, 2);
        step(0, 0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h11, 4);
        step(0, 0, 1, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22, 4);
        step(0, 0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h11, 2);
        // Early release of req0 after 2 grant cycles: gnt1 gets a full 4-cycle burst.
        step(0, 0, 0, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22, 1);
        step(0, 0, 1, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22, 3);
        step(0, 0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h11, 1);
        step(0, 0, 0, 0, 8'h11, 8'h22, 0, 0, 0, 8'h00, 1);
        // Single requester for 10 cycles: re-granted across burst expiry without a gap.
        step(0, 0, 1, 0, 8'hA5, 8'h5A, 1, 0, 0, 8'hA5, 10);
        step(0, 0, 0, 0, 8'hA5, 8'h5A, 0, 0, 0, 8'h00, 1);
        // Reset asserted in the 2nd cycle of G1; req0 must win afterwards.
        step(0, 0, 0, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22, 1);
        step(0, 0, 1, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22, 1);
        step(0, 1, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h11, 2);
        // Handover to req1 alone, then idle: s holds 1 while y is forced to zero.
        step(0, 0, 0, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22, 1);
        step(0, 0, 0, 0, 8'h11, 8'h22, 0, 0, 1, 8'h00, 1);
        // MAXBURST=1: grants alternate every cycle.
        step(1, 1, 1, 1, 8'h33, 8'h44, 0, 0, 0, 8'h00, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 1, 1, 8'h33, 8'h44, 1, 0, 0, 8'h33, 1);
            step(1, 0, 1, 1, 8'h33, 8'h44, 0, 1, 1, 8'h44, 1);
        end
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        #2;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
